// File: rtl/pipe_pkg.sv
// Shared pipeline types for the memory stage: FSM states,
// access-size encodings and the MEM/WB register bundle.
package pipe_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } memstate_t;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef struct packed {
    logic        regwrite;
    logic        memtoreg;
    logic        misalign;
    logic [31:0] readdata;
    logic [31:0] aluout;
    logic [4:0]  writereg;
  } memwb_t;

  localparam memwb_t MEMWB_BUBBLE = '0;

endpackage

// File: rtl/memory_stage_if.sv
// Request/acknowledge data-memory port.
// master = pipeline side, slave = memory side.
interface memory_stage_if #(
  parameter int ADDR_W = 32
);
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [3:0]        dmem_be;
  logic [31:0]       dmem_wdata;
  logic              dmem_ack;
  logic [31:0]       dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr,
    output dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr,
    input  dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/load_align.sv
// Sub-word load lane select and sign/zero extension.
// Built only when MEMSTAGE_SUBWORD_EN is defined.
`ifdef MEMSTAGE_SUBWORD_EN
module load_align
  import pipe_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[8*lane +: 8];
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    data = rdata;
    unique case (1'b1)
      (size == SZ_BYTE):
        data = {{24{b[7] & ~uns}}, b};
      (size == SZ_HALF):
        data = {{16{h[15] & ~uns}}, h};
      default:
        data = rdata;
    endcase
  end
endmodule
`endif

// File: rtl/memory_stage.sv
// MIPS memory-access stage: dmem handshake FSM plus MEM/WB register.
// Sub-word accesses enabled by MEMSTAGE_SUBWORD_EN.
module memory_stage
  import pipe_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        regwriteM,
  input  logic        memtoregM,
  input  logic        memwriteM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  input  logic [4:0]  writeregM,
  input  logic [1:0]  sizeM,
  input  logic        unsignedM,
  memory_stage_if.master dmem,
  output logic        stallM,
  output logic        regwriteW,
  output logic        memtoregW,
  output logic [31:0] readdataW,
  output logic [31:0] aluoutW,
  output logic [4:0]  writeregW,
  output logic        misalignW
);
  memstate_t   state_q, state_d;
  memwb_t      wb_q, wb_d;
  logic        memop, req, misalign;
  logic        load_done;
  logic [1:0]  sz;
  logic [3:0]  be;
  logic [31:0] wdata, aligned, ld_data;

  assign memop = memtoregM | memwriteM;

`ifdef MEMSTAGE_SUBWORD_EN
  assign sz = sizeM;

  load_align u_align (
    .rdata (dmem.dmem_rdata),
    .lane  (aluoutM[1:0]),
    .size  (sizeM),
    .uns   (unsignedM),
    .data  (aligned)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^{sizeM, unsignedM};
  assign sz = SZ_WORD;
  assign aligned = dmem.dmem_rdata;
`endif

  always_comb begin
    misalign = 1'b0;
    be = 4'b1111;
    wdata = writedataM;
    unique case (1'b1)
      (sz == SZ_BYTE): begin
        be = 4'b0001 << aluoutM[1:0];
        wdata = {4{writedataM[7:0]}};
      end
      (sz == SZ_HALF): begin
        misalign = aluoutM[0];
        be = aluoutM[1] ? 4'b1100 : 4'b0011;
        wdata = {2{writedataM[15:0]}};
      end
      default:
        misalign = |aluoutM[1:0];
    endcase
    if (misalign) be = 4'b0000;
  end

  // WAIT keeps the request up; upstream holds the M fields stable.
  always_comb begin
    state_d = state_q;
    req = 1'b0;
    unique case (state_q)
      IDLE: begin
        req = memop;
        if (memop && !dmem.dmem_ack) state_d = WAIT;
      end
      WAIT: begin
        req = 1'b1;
        if (dmem.dmem_ack) state_d = IDLE;
      end
    endcase
    if (reset) begin
      req = 1'b0;
      state_d = IDLE;
    end
  end

  assign stallM = req & ~dmem.dmem_ack;
  assign dmem.dmem_req = req;
  assign dmem.dmem_we = req & memwriteM;
  assign dmem.dmem_addr = {aluoutM[ADDR_W-1:2], 2'b00};
  assign dmem.dmem_be = be;
  assign dmem.dmem_wdata = wdata;

  assign load_done = req & dmem.dmem_ack
                   & memtoregM & ~memwriteM;
  assign ld_data = misalign ? 32'h0 : aligned;

  always_comb begin
    wb_d = wb_q;
    if (stallM) begin
      wb_d.regwrite = MEMWB_BUBBLE.regwrite;
      wb_d.memtoreg = MEMWB_BUBBLE.memtoreg;
      wb_d.misalign = MEMWB_BUBBLE.misalign;
    end else begin
      wb_d.regwrite = regwriteM;
      wb_d.memtoreg = memtoregM;
      wb_d.misalign = memop & misalign;
      wb_d.aluout = aluoutM;
      wb_d.writereg = writeregM;
      if (load_done) wb_d.readdata = ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wb_q <= MEMWB_BUBBLE;
    end else begin
      state_q <= state_d;
      wb_q <= wb_d;
    end
  end

  assign regwriteW = wb_q.regwrite;
  assign memtoregW = wb_q.memtoreg;
  assign misalignW = wb_q.misalign;
  assign readdataW = wb_q.readdata;
  assign aluoutW = wb_q.aluout;
  assign writeregW = wb_q.writereg;
endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage with a scoreboard of
// expected MEM/WB contents.
module tb_memory_stage;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        regwriteM, memtoregM, memwriteM;
  logic [31:0] aluoutM, writedataM;
  logic [4:0]  writeregM;
  logic [1:0]  sizeM;
  logic        unsignedM;
  logic        stallM, regwriteW, memtoregW, misalignW;
  logic [31:0] readdataW, aluoutW;
  logic [4:0]  writeregW;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rw;
    logic        m2r;
    logic        mis;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  wr;
    bit          chk_data;
    bit          chk_rd;
  } exp_t;

  exp_t sb[$];

  memory_stage_if #(.ADDR_W(32)) dmem_if ();

  memory_stage #(.ADDR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .regwriteM  (regwriteM),
    .memtoregM  (memtoregM),
    .memwriteM  (memwriteM),
    .aluoutM    (aluoutM),
    .writedataM (writedataM),
    .writeregM  (writeregM),
    .sizeM      (sizeM),
    .unsignedM  (unsignedM),
    .dmem       (dmem_if),
    .stallM     (stallM),
    .regwriteW  (regwriteW),
    .memtoregW  (memtoregW),
    .readdataW  (readdataW),
    .aluoutW    (aluoutW),
    .writeregW  (writeregW),
    .misalignW  (misalignW)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rw, input logic m2r,
                       input logic mw, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] wr,
                       input logic [1:0] sz, input logic u);
    regwriteM = rw;
    memtoregM = m2r;
    memwriteM = mw;
    aluoutM = a;
    writedataM = wd;
    writeregM = wr;
    sizeM = sz;
    unsignedM = u;
  endtask

  task automatic push(input logic rw, input logic m2r,
                      input logic mis, input logic [31:0] rd,
                      input logic [31:0] alu, input logic [4:0] wr,
                      input bit cd, input bit cr);
    exp_t e;
    e.rw = rw; e.m2r = m2r; e.mis = mis;
    e.rd = rd; e.alu = alu; e.wr = wr;
    e.chk_data = cd; e.chk_rd = cr;
    sb.push_back(e);
  endtask

  task automatic bubble();
    push(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  // Advance one edge, then compare W against the oldest expectation.
  task automatic step_check(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_regwriteW"}, 32'(regwriteW), 32'(e.rw));
      chk({tag, "_memtoregW"}, 32'(memtoregW), 32'(e.m2r));
      chk({tag, "_misalignW"}, 32'(misalignW), 32'(e.mis));
      if (e.chk_data) begin
        chk({tag, "_aluoutW"}, aluoutW, e.alu);
        chk({tag, "_writeregW"}, 32'(writeregW), 32'(e.wr));
      end
      if (e.chk_rd) chk({tag, "_readdataW"}, readdataW, e.rd);
    end
  endtask

  initial begin
    int stalls;
    reset = 1'b1;
    dmem_if.dmem_ack = 1'b0;
    dmem_if.dmem_rdata = '0;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, SZ_WORD, 1'b0);
    @(posedge clk);
    push(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1);
    step_check("reset");
    chk("reset_req", 32'(dmem_if.dmem_req), 32'd0);
    chk("reset_stall", 32'(stallM), 32'd0);
    reset = 1'b0;

    // Zero-wait load word.
    drive(1'b1, 1'b1, 1'b0, 32'h10, '0, 5'd3, SZ_WORD, 1'b0);
    dmem_if.dmem_ack = 1'b1;
    dmem_if.dmem_rdata = 32'hDEADBEEF;
    #1;
    chk("lw_req", 32'(dmem_if.dmem_req), 32'd1);
    chk("lw_stall", 32'(stallM), 32'd0);
    chk("lw_be", 32'(dmem_if.dmem_be), 32'hF);
    chk("lw_addr", dmem_if.dmem_addr, 32'h10);
    push(1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 32'h10, 5'd3, 1'b1, 1'b1);
    step_check("lw");

    // Store word with three wait cycles.
    drive(1'b0, 1'b0, 1'b1, 32'h20, 32'h12345678, 5'd0,
          SZ_WORD, 1'b0);
    dmem_if.dmem_ack = 1'b0;
    dmem_if.dmem_rdata = 32'h0BAD0BAD;
    stalls = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (stallM) stalls++;
      chk("sw_we", 32'(dmem_if.dmem_we), 32'd1);
      chk("sw_addr", dmem_if.dmem_addr, 32'h20);
      chk("sw_wdata", dmem_if.dmem_wdata, 32'h12345678);
      bubble();
      step_check("sw_wait");
    end
    dmem_if.dmem_ack = 1'b1;
    #1;
    if (stallM) stalls++;
    chk("sw_stalls", 32'(stalls), 32'd3);
    chk("sw_ack_addr", dmem_if.dmem_addr, 32'h20);
    push(1'b0, 1'b0, 1'b0, '0, 32'h20, 5'd0, 1'b1, 1'b0);
    step_check("sw_done");

    // Misaligned load word.
    drive(1'b1, 1'b1, 1'b0, 32'h22, '0, 5'd7, SZ_WORD, 1'b0);
    dmem_if.dmem_rdata = 32'hCAFEF00D;
    #1;
    chk("mis_be", 32'(dmem_if.dmem_be), 32'h0);
    chk("mis_addr", dmem_if.dmem_addr, 32'h20);
    push(1'b1, 1'b1, 1'b1, 32'h0, 32'h22, 5'd7, 1'b1, 1'b1);
    step_check("mis");

`ifdef MEMSTAGE_SUBWORD_EN
    drive(1'b1, 1'b1, 1'b0, 32'h23, '0, 5'd8, SZ_BYTE, 1'b0);
    dmem_if.dmem_rdata = 32'h80FF0000;
    push(1'b1, 1'b1, 1'b0, 32'hFFFFFF80, 32'h23, 5'd8, 1'b1, 1'b1);
    step_check("lb");
    unsignedM = 1'b1;
    push(1'b1, 1'b1, 1'b0, 32'h00000080, 32'h23, 5'd8, 1'b1, 1'b1);
    step_check("lbu");
    drive(1'b0, 1'b0, 1'b1, 32'h21, 32'h000000AB, 5'd0,
          SZ_BYTE, 1'b0);
    #1;
    chk("sb_be", 32'(dmem_if.dmem_be), 32'b0010);
    chk("sb_wdata", dmem_if.dmem_wdata, 32'hABABABAB);
    push(1'b0, 1'b0, 1'b0, '0, 32'h21, 5'd0, 1'b1, 1'b0);
    step_check("sb");
`endif

    // ALU op, stray ack without a request.
    drive(1'b1, 1'b0, 1'b0, 32'h55, '0, 5'd9, SZ_WORD, 1'b0);
    dmem_if.dmem_ack = 1'b1;
    #1;
    chk("alu_req", 32'(dmem_if.dmem_req), 32'd0);
    chk("alu_stall", 32'(stallM), 32'd0);
    push(1'b1, 1'b0, 1'b0, '0, 32'h55, 5'd9, 1'b1, 1'b0);
    step_check("alu");

    // Back-to-back zero-wait loads.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h40 + 32'(4 * i), '0,
            5'(10 + i), SZ_WORD, 1'b0);
      dmem_if.dmem_rdata = 32'hA5000000 + 32'(i);
      #1;
      chk("b2b_req", 32'(dmem_if.dmem_req), 32'd1);
      chk("b2b_stall", 32'(stallM), 32'd0);
      push(1'b1, 1'b1, 1'b0, 32'hA5000000 + 32'(i),
           32'h40 + 32'(4 * i), 5'(10 + i), 1'b1, 1'b1);
      step_check("b2b");
    end

    // Reset on the second WAIT cycle abandons the access.
    drive(1'b1, 1'b1, 1'b0, 32'h60, '0, 5'd12, SZ_WORD, 1'b0);
    dmem_if.dmem_ack = 1'b0;
    bubble();
    step_check("rw_issue");
    chk("rw_wait1_stall", 32'(stallM), 32'd1);
    bubble();
    step_check("rw_wait1");
    reset = 1'b1;
    #1;
    chk("rw_req", 32'(dmem_if.dmem_req), 32'd0);
    chk("rw_stall", 32'(stallM), 32'd0);
    push(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1);
    step_check("rw_reset");
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, SZ_WORD, 1'b0);
    #1;
    chk("rw_idle_req", 32'(dmem_if.dmem_req), 32'd0);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain observed=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
